mor1kx_spr_cfg_slave: RTL and testbench

- SPR bus slave for the read-only configuration/version registers of SPR group 0 (index 0..10).
- Sits downstream of the configuration-register block. Consumes its eleven 32-bit constant outputs and answers mor1kx SPR bus accesses to them with a registered, handshaked response.
- Its data output is zero whenever no ack is given, so it can be OR-combined with the other group-0 slaves in the SPR read mux.

---
 rtl/mor1kx_spr_cfg_slave.sv | 127 ++++++++++++
 tb/tb_mor1kx_spr_cfg_slave.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_spr_cfg_slave.sv
// rtl/mor1kx_spr_cfg_slave.sv - SPR bus slave answering reads of group-0 config/version registers
// Optional feature macro: MOR1KX_SPR_CFG_WRITE_ERR_EN (flag write hits with spr_cfg_err_o)
module mor1kx_spr_cfg_slave #(
  parameter int OPTION_SPR_ADDR_WIDTH = 16,
  parameter int OPTION_CFG_LAST_INDEX = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [OPTION_SPR_ADDR_WIDTH-1:0] spr_bus_addr_i,
  input  logic                             spr_bus_we_i,
  input  logic                             spr_bus_stb_i,
  input  logic [31:0]                      spr_bus_dat_i,
  input  logic [31:0]                      spr_vr,
  input  logic [31:0]                      spr_vr2,
  input  logic [31:0]                      spr_upr,
  input  logic [31:0]                      spr_cpucfgr,
  input  logic [31:0]                      spr_dmmucfgr,
  input  logic [31:0]                      spr_immucfgr,
  input  logic [31:0]                      spr_dccfgr,
  input  logic [31:0]                      spr_iccfgr,
  input  logic [31:0]                      spr_dcfgr,
  input  logic [31:0]                      spr_pccfgr,
  input  logic [31:0]                      spr_avr,
  output logic                             spr_cfg_ack_o,
  output logic [31:0]                      spr_cfg_dat_o,
  output logic                             spr_cfg_err_o,
  output logic                             spr_cfg_busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [10:0] LAST_INDEX = 11'(OPTION_CFG_LAST_INDEX);

  state_t      state;
  state_t      state_next;
  logic        load;
  logic        hit;
  logic        group_zero;
  logic [10:0] index;
  logic [31:0] sel_value;
  logic [31:0] data_q;
  logic        we_q;

  assign index      = spr_bus_addr_i[10:0];
  assign group_zero = (spr_bus_addr_i[OPTION_SPR_ADDR_WIDTH-1:11] == '0);
  assign hit        = spr_bus_stb_i & group_zero & (index <= LAST_INDEX);

  // Select the config register addressed by the group-0 index
  always_comb begin
    sel_value = '0;
    case (index)
      11'd0:   sel_value = spr_vr;
      11'd1:   sel_value = spr_upr;
      11'd2:   sel_value = spr_cpucfgr;
      11'd3:   sel_value = spr_dmmucfgr;
      11'd4:   sel_value = spr_immucfgr;
      11'd5:   sel_value = spr_dccfgr;
      11'd6:   sel_value = spr_iccfgr;
      11'd7:   sel_value = spr_dcfgr;
      11'd8:   sel_value = spr_pccfgr;
      11'd9:   sel_value = spr_vr2;
      11'd10:  sel_value = spr_avr;
      default: sel_value = '0;
    endcase
  end

  // Next-state logic: one ack per strobe, then wait for the strobe to drop
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          state_next = ST_ACK;
          load       = 1'b1;
        end
      end
      ST_ACK:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (!spr_bus_stb_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset drops any pending response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture response data and direction only on the IDLE->ACK edge
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      we_q   <= 1'b0;
    end else if (load) begin
      data_q <= spr_bus_we_i ? 32'd0 : sel_value;
      we_q   <= spr_bus_we_i;
    end
  end

  // Data is forced to zero outside the ack cycle so the read mux can OR slaves together
  assign spr_cfg_ack_o  = (state == ST_ACK);
  assign spr_cfg_dat_o  = spr_cfg_ack_o ? data_q : 32'd0;
  assign spr_cfg_busy_o = (state != ST_IDLE);

`ifdef MOR1KX_SPR_CFG_WRITE_ERR_EN
  assign spr_cfg_err_o = spr_cfg_ack_o & we_q;
  logic unused_inputs;
  assign unused_inputs = ^spr_bus_dat_i;
`else
  assign spr_cfg_err_o = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{spr_bus_dat_i, we_q};
`endif

endmodule

// File: tb/tb_mor1kx_spr_cfg_slave.sv
// tb/tb_mor1kx_spr_cfg_slave.sv - directed self-checking bench for mor1kx_spr_cfg_slave
module tb_mor1kx_spr_cfg_slave;

  logic        clk;
  logic        rst;
  logic [15:0] spr_bus_addr_i;
  logic        spr_bus_we_i;
  logic        spr_bus_stb_i;
  logic [31:0] spr_bus_dat_i;
  logic [31:0] spr_vr, spr_vr2, spr_upr, spr_cpucfgr;
  logic [31:0] spr_dmmucfgr, spr_immucfgr, spr_dccfgr, spr_iccfgr;
  logic [31:0] spr_dcfgr, spr_pccfgr, spr_avr;
  logic        spr_cfg_ack_o;
  logic [31:0] spr_cfg_dat_o;
  logic        spr_cfg_err_o;
  logic        spr_cfg_busy_o;

  int checks;
  int failures;

`ifdef MOR1KX_SPR_CFG_WRITE_ERR_EN
  localparam logic EXP_WR_ERR = 1'b1;
`else
  localparam logic EXP_WR_ERR = 1'b0;
`endif

  mor1kx_spr_cfg_slave dut (
    .clk            (clk),
    .rst            (rst),
    .spr_bus_addr_i (spr_bus_addr_i),
    .spr_bus_we_i   (spr_bus_we_i),
    .spr_bus_stb_i  (spr_bus_stb_i),
    .spr_bus_dat_i  (spr_bus_dat_i),
    .spr_vr         (spr_vr),
    .spr_vr2        (spr_vr2),
    .spr_upr        (spr_upr),
    .spr_cpucfgr    (spr_cpucfgr),
    .spr_dmmucfgr   (spr_dmmucfgr),
    .spr_immucfgr   (spr_immucfgr),
    .spr_dccfgr     (spr_dccfgr),
    .spr_iccfgr     (spr_iccfgr),
    .spr_dcfgr      (spr_dcfgr),
    .spr_pccfgr     (spr_pccfgr),
    .spr_avr        (spr_avr),
    .spr_cfg_ack_o  (spr_cfg_ack_o),
    .spr_cfg_dat_o  (spr_cfg_dat_o),
    .spr_cfg_err_o  (spr_cfg_err_o),
    .spr_cfg_busy_o (spr_cfg_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and let outputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full access with stb held until ack, then dropped
  task automatic access(input string tag, input logic [15:0] addr, input logic we,
                        input logic [31:0] exp_dat, input logic exp_err);
    spr_bus_addr_i = addr;
    spr_bus_we_i   = we;
    spr_bus_stb_i  = 1'b1;
    #1;
    check({tag, "_pre_ack"}, {31'd0, spr_cfg_ack_o}, 32'd0);
    tick();
    check({tag, "_ack"}, {31'd0, spr_cfg_ack_o}, 32'd1);
    check({tag, "_dat"}, spr_cfg_dat_o, exp_dat);
    check({tag, "_err"}, {31'd0, spr_cfg_err_o}, {31'd0, exp_err});
    tick();
    check({tag, "_wait_ack"}, {31'd0, spr_cfg_ack_o}, 32'd0);
    check({tag, "_wait_dat"}, spr_cfg_dat_o, 32'd0);
    check({tag, "_wait_busy"}, {31'd0, spr_cfg_busy_o}, 32'd1);
    spr_bus_stb_i = 1'b0;
    spr_bus_we_i  = 1'b0;
    tick();
    check({tag, "_idle_busy"}, {31'd0, spr_cfg_busy_o}, 32'd0);
  endtask

  // Hold stb on a non-claimed address and count any response
  task automatic miss(input string tag, input logic [15:0] addr);
    int acks;
    int busys;
    int dats;
    acks = 0; busys = 0; dats = 0;
    spr_bus_addr_i = addr;
    spr_bus_stb_i  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (spr_cfg_ack_o) acks++;
      if (spr_cfg_busy_o) busys++;
      if (spr_cfg_dat_o != 32'd0) dats++;
    end
    check({tag, "_acks"}, 32'(acks), 32'd0);
    check({tag, "_busy"}, 32'(busys), 32'd0);
    check({tag, "_dat"}, 32'(dats), 32'd0);
    spr_bus_stb_i = 1'b0;
    tick();
  endtask

  initial begin
    int          acks;
    logic [31:0] ack_dat;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    spr_bus_addr_i = 16'h0;
    spr_bus_we_i   = 1'b0;
    spr_bus_stb_i  = 1'b0;
    spr_bus_dat_i  = 32'h0;
    spr_vr       = 32'h10000040;
    spr_upr      = 32'h0000071D;
    spr_cpucfgr  = 32'h00000320;
    spr_dmmucfgr = 32'h00000018;
    spr_immucfgr = 32'h00000019;
    spr_dccfgr   = 32'h000000A0;
    spr_iccfgr   = 32'h000000A1;
    spr_dcfgr    = 32'h00000002;
    spr_pccfgr   = 32'h00000005;
    spr_vr2      = 32'h32000000;
    spr_avr      = 32'h01010000;

    tick();
    tick();
    check("rst_ack", {31'd0, spr_cfg_ack_o}, 32'd0);
    check("rst_dat", spr_cfg_dat_o, 32'd0);
    check("rst_err", {31'd0, spr_cfg_err_o}, 32'd0);
    check("rst_busy", {31'd0, spr_cfg_busy_o}, 32'd0);
    rst = 1'b0;
    tick();

    access("rd_vr", 16'h0000, 1'b0, 32'h10000040, 1'b0);
    access("rd_avr", 16'h000A, 1'b0, 32'h01010000, 1'b0);
    access("rd_vr2", 16'h0009, 1'b0, 32'h32000000, 1'b0);
    access("rd_dcfgr", 16'h0007, 1'b0, 32'h00000002, 1'b0);
    miss("miss_idx11", 16'h000B);
    miss("miss_grp1", 16'h0800);

    // Held strobe yields exactly one ack, then a fresh strobe gets a second one
    acks = 0;
    ack_dat = 32'h0;
    spr_bus_addr_i = 16'h0002;
    spr_bus_stb_i  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (spr_cfg_ack_o) begin
        acks++;
        ack_dat = spr_cfg_dat_o;
      end
    end
    check("held_acks", 32'(acks), 32'd1);
    check("held_dat", ack_dat, 32'h00000320);
    spr_bus_stb_i = 1'b0;
    tick();
    spr_bus_stb_i = 1'b1;
    tick();
    check("reassert_ack", {31'd0, spr_cfg_ack_o}, 32'd1);
    check("reassert_dat", spr_cfg_dat_o, 32'h00000320);
    spr_bus_stb_i = 1'b0;
    tick();
    tick();

    // Write hit: acked, data zero, err only when the feature is built in
    spr_bus_dat_i = 32'hFFFFFFFF;
    access("wr_upr", 16'h0001, 1'b1, 32'h0, EXP_WR_ERR);
    spr_bus_dat_i = 32'h0;
    access("rd_upr_after_wr", 16'h0001, 1'b0, 32'h0000071D, 1'b0);

    // Reset in the ack cycle drops the response
    spr_bus_addr_i = 16'h0003;
    spr_bus_stb_i  = 1'b1;
    tick();
    check("rstmid_ack", {31'd0, spr_cfg_ack_o}, 32'd1);
    rst = 1'b1;
    tick();
    check("rstmid_after_ack", {31'd0, spr_cfg_ack_o}, 32'd0);
    check("rstmid_after_dat", spr_cfg_dat_o, 32'd0);
    check("rstmid_after_busy", {31'd0, spr_cfg_busy_o}, 32'd0);
    rst = 1'b0;
    spr_bus_stb_i = 1'b0;
    tick();
    access("rd_after_rst", 16'h0003, 1'b0, 32'h00000018, 1'b0);

    // Reset and hit in the same cycle: no ack
    rst = 1'b1;
    spr_bus_addr_i = 16'h0004;
    spr_bus_stb_i  = 1'b1;
    tick();
    check("rsthit_ack", {31'd0, spr_cfg_ack_o}, 32'd0);
    check("rsthit_busy", {31'd0, spr_cfg_busy_o}, 32'd0);
    rst = 1'b0;
    spr_bus_stb_i = 1'b0;
    tick();

    // Config change after the sample edge does not alter the response
    spr_bus_addr_i = 16'h0008;
    spr_bus_stb_i  = 1'b1;
    tick();
    spr_pccfgr = 32'h00000007;
    spr_bus_addr_i = 16'h0000;
    #1;
    check("late_chg_ack", {31'd0, spr_cfg_ack_o}, 32'd1);
    check("late_chg_dat", spr_cfg_dat_o, 32'h00000005);
    tick();
    check("late_chg_wait_ack", {31'd0, spr_cfg_ack_o}, 32'd0);
    spr_bus_stb_i = 1'b0;
    tick();
    access("rd_pccfgr_new", 16'h0008, 1'b0, 32'h00000007, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
